// File: rtl/mac_pkg.sv
// Shared constants for the MAC array and its output partial-sum FIFO.
package mac_pkg;

    // MAC-array geometry
    localparam int BW          = 4;
    localparam int ROW         = 8;
    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;

    // Output FIFO sizing
    localparam int OFIFO_DEPTH = 16;

    // Bit positions inside the sticky err vector
    localparam int ERR_OVF     = 0;
    localparam int ERR_UDF     = 1;

    // Pointer width for a FIFO of the given depth (at least one bit)
    function automatic int ptr_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane show-ahead circular FIFO: one column of the partial-sum output buffer.
module ofifo_lane
    import mac_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] head,
    output logic               empty,
    output logic               full
);

    localparam int AW = ptr_width(depth);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [AW:0]        cnt;
    logic               wr_ok;

    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);

    // A full lane can still take a write when the same edge frees a slot.
    assign wr_ok = wr & (~full | pop);

    // Empty lanes present zero so stale storage never leaks to the bus.
    assign head = empty ? '0 : mem[rptr];

    // Storage has no reset; contents are only visible while occupied.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Row-aligning output FIFO for MAC-array partial sums: one lane per column,
// lanes fill independently (diagonal skew) and are popped together as a row.
module psum_ofifo
    import mac_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [1:0]             err
);

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic           pop;
    logic           ovf;
    logic           udf;

    // Row status comes only from registered lane occupancy.
    assign o_valid = &(~lane_empty);
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;

    // A row pop is legal only when every lane has its element.
    assign pop = rd & o_valid;
    assign ovf = |(wr & lane_full & ~{col{pop}});
    assign udf = rd & ~o_valid;

    for (genvar j = 0; j < col; j++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[j]),
            .pop   (pop),
            .din   (in[psum_bw*j +: psum_bw]),
            .head  (out[psum_bw*j +: psum_bw]),
            .empty (lane_empty[j]),
            .full  (lane_full[j])
        );
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= '0;
        end else begin
            if (ovf) begin
                err[ERR_OVF] <= 1'b1;
            end
            if (udf) begin
                err[ERR_UDF] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo with a row scoreboard.
module tb_psum_ofifo;
    import mac_pkg::*;

    localparam int C   = COL;
    localparam int BWD = PSUM_BW;
    localparam int D   = OFIFO_DEPTH;
    localparam int W   = C * BWD;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_bus;
    logic [C-1:0] wr;
    logic         rd;
    logic [W-1:0] out_bus;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
    logic [1:0]   err;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    psum_ofifo dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_bus),
        .wr      (wr),
        .rd      (rd),
        .out     (out_bus),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_row(input int base);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < C; j++) r[j*BWD +: BWD] = BWD'(base + j);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1ns later.
    task automatic cycle(input logic [C-1:0] wr_v, input logic [W-1:0] in_v, input logic rd_v);
        wr     = wr_v;
        in_bus = in_v;
        rd     = rd_v;
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    // Compare head against scoreboard then pop one row.
    task automatic pop_row(input string tag);
        logic [W-1:0] exp;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=scoreboard_empty expected=row", tag);
        end else begin
            exp = sb.pop_front();
            chk(tag, out_bus, exp);
        end
        cycle('0, '0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
    endtask

    initial begin
        logic [W-1:0] exp;
        logic [C-1:0] m;
        logic [W-1:0] v;
        int r;

        reset  = 1'b0;
        wr     = '0;
        rd     = 1'b0;
        in_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", W'(o_valid), W'(1'b0));
        chk("rst_full",  W'(o_full),  W'(1'b0));
        chk("rst_ready", W'(o_ready), W'(1'b1));
        chk("rst_out",   out_bus,     '0);
        chk("rst_err",   W'(err),     W'(2'b00));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Aligned single row
        cycle('1, mk_row(1), 1'b0);
        chk("al_valid", W'(o_valid), W'(1'b1));
        chk("al_out",   out_bus,     mk_row(1));
        cycle('0, '0, 1'b1);
        chk("al_pop_valid", W'(o_valid), W'(1'b0));
        chk("al_pop_out",   out_bus,     '0);

        // Diagonal skew: lane j writes row r at cycle r+j
        for (int k = 0; k < 4; k++) sb.push_back(mk_row(16*k));
        for (int c = 0; c < 4 + C - 1; c++) begin
            m = '0;
            v = '0;
            for (int j = 0; j < C; j++) begin
                r = c - j;
                if (r >= 0 && r < 4) begin
                    m[j] = 1'b1;
                    v[j*BWD +: BWD] = BWD'(16*r + j);
                end
            end
            cycle(m, v, 1'b0);
            chk($sformatf("skew_valid_c%0d", c), W'(o_valid), W'(c >= C - 1));
        end
        for (int k = 0; k < 4; k++) pop_row($sformatf("skew_pop%0d", k));
        chk("skew_drained", W'(o_valid), W'(1'b0));

        // Fill to full, then overflow attempt
        for (int k = 0; k < D; k++) begin
            cycle('1, mk_row(256*k), 1'b0);
            sb.push_back(mk_row(256*k));
        end
        chk("fill_full",  W'(o_full),  W'(1'b1));
        chk("fill_ready", W'(o_ready), W'(1'b0));
        chk("fill_err",   W'(err),     W'(2'b00));
        cycle('1, mk_row(16'h7700), 1'b0);
        chk("ovf_err",  W'(err),     W'(2'b01));
        chk("ovf_head", out_bus,     mk_row(0));
        chk("ovf_full", W'(o_full),  W'(1'b1));
        for (int k = 0; k < D; k++) pop_row($sformatf("fill_pop%0d", k));
        chk("fill_drained", W'(o_valid), W'(1'b0));
        chk("fill_notfull", W'(o_full),  W'(1'b0));

        // Simultaneous write and pop at full
        do_reset();
        for (int k = 0; k < D; k++) begin
            cycle('1, mk_row(1000 + 16*k), 1'b0);
            sb.push_back(mk_row(1000 + 16*k));
        end
        chk("wp_head", out_bus, sb[0]);
        void'(sb.pop_front());
        sb.push_back(mk_row(5000));
        cycle('1, mk_row(5000), 1'b1);
        chk("wp_full", W'(o_full), W'(1'b1));
        chk("wp_err",  W'(err),    W'(2'b00));
        for (int k = 0; k < D; k++) pop_row($sformatf("wp_pop%0d", k));
        chk("wp_drained", W'(o_valid), W'(1'b0));

        // Underflow: lane 3 empty, others hold one entry
        cycle(8'hF7, mk_row(80), 1'b0);
        exp = mk_row(80);
        exp[3*BWD +: BWD] = '0;
        chk("udf_pre_valid", W'(o_valid), W'(1'b0));
        cycle('0, '0, 1'b1);
        chk("udf_err",  W'(err),    W'(2'b10));
        chk("udf_out",  out_bus,    exp);
        repeat (10) cycle('0, '0, 1'b0);
        chk("udf_sticky", W'(err), W'(2'b10));
        cycle(8'h08, mk_row(80), 1'b0);
        chk("udf_fix_valid", W'(o_valid), W'(1'b1));
        sb.push_back(mk_row(80));
        pop_row("udf_fix_pop");
        chk("udf_fix_drained", W'(o_valid), W'(1'b0));

        // Reset mid-stream, asserted between edges
        for (int k = 0; k < 5; k++) cycle('1, mk_row(768 + 16*k), 1'b0);
        chk("mid_valid_pre", W'(o_valid), W'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valid", W'(o_valid), W'(1'b0));
        chk("mid_out",   out_bus,     '0);
        chk("mid_err",   W'(err),     W'(2'b00));
        chk("mid_ready", W'(o_ready), W'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        cycle('1, mk_row(16'h0770), 1'b0);
        sb.push_back(mk_row(16'h0770));
        chk("post_valid", W'(o_valid), W'(1'b1));
        pop_row("post_pop");
        chk("post_empty", W'(o_valid), W'(1'b0));
        chk("post_err",   W'(err),     W'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
